// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer with a running population count and a
// one-word output register under valid/ready flow control.
module serial_word_packer #(
    parameter int  WIDTH     = 8,
    parameter int  LSB_FIRST = 1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_ones
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    ones_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    out_ones_r;

    logic             last_s;
    logic             accept_s;
    logic             complete_s;
    logic [CW-1:0]    pos_s;
    logic [WIDTH-1:0] merged_s;
    logic [CW-1:0]    ones_inc_s;

    // Handshake decode; a stalled last bit waits only while the held word is not taken.
    always_comb begin
        last_s     = (cnt_r == CW'(WIDTH - 1));
        in_ready   = !(last_s && (state_r == ST_FULL) && !out_ready);
        accept_s   = in_valid && in_ready && !clear;
        complete_s = accept_s && last_s;
        ones_inc_s = ones_r + {{(CW-1){1'b0}}, in_bit};
    end

    // Bit placement: insert the incoming bit at its slot in the accumulator.
    always_comb begin
        if (LSB_FIRST != 0) begin
            pos_s = cnt_r;
        end else begin
            pos_s = CW'(WIDTH - 1) - cnt_r;
        end
        merged_s = acc_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos_s == CW'(i)) begin
                merged_s[i] = in_bit;
            end else begin
                merged_s[i] = acc_r[i];
            end
        end
    end

    // Output FSM next-state: a completing word always (re)fills the register.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (complete_s) begin
                    state_nx_s = ST_FULL;
                end else if (out_ready) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: state_nx_s = ST_EMPTY;
        endcase
    end

    // Accumulator: shift register, bit counter and running ones count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            ones_r <= {CW{1'b0}};
        end else if (clear) begin
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            ones_r <= {CW{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                acc_r  <= {WIDTH{1'b0}};
                cnt_r  <= {CW{1'b0}};
                ones_r <= {CW{1'b0}};
            end else begin
                acc_r  <= merged_s;
                cnt_r  <= cnt_r + CW'(1);
                ones_r <= ones_inc_s;
            end
        end
    end

    // Output register: loads only on word completion so held data stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            out_data_r <= {WIDTH{1'b0}};
            out_ones_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (complete_s) begin
                out_data_r <= merged_s;
                out_ones_r <= ones_inc_s;
            end
        end
    end

    assign out_valid = (state_r == ST_FULL);
    assign out_data  = out_data_r;
    assign out_ones  = out_ones_r;

endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Upstream stage of the bit-majority voter. Collects a serial bit stream under a valid/ready handshake and packs it into `WIDTH`-bit words. Each finished word is presented on a registered output with valid/ready flow control, together with its population count, so the voter and any threshold logic downstream receive `out_data` and `out_ones` as a single aligned transfer. A partial word is accumulated while the previous word waits at the output, which gives two words of buffering in total.

## Interface

- `WIDTH`, default 8: word length in bits; must be ≥2.
- `LSB_FIRST`, default 1: when 1, the first accepted bit lands in `out_data[0]`; when 0, it lands in `out_data[WIDTH-1]`.
- `CW`, derived as `$clog2(WIDTH+1)`: width of the ones count.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of the partial word.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `in_ready`  out  1  the block will accept `in_bit` this cycle.
- `out_valid`  out  1  a completed word is held on the output.
- `out_ready`  in  1  downstream takes the word this cycle.
- `out_data`  out  WIDTH  the completed word.
- `out_ones`  out  CW  number of 1s in `out_data`, from 0 to WIDTH.

## Operation

- **Accept rule.** A bit is accepted when `in_valid && in_ready && !clear`.
- **Accumulator.** The accumulator holds a shift register `acc`, a bit counter `cnt` (0..WIDTH-1) and a running ones count `ones`.
  - Each accepted bit is placed at position `cnt` (or `WIDTH-1-cnt` when `LSB_FIRST=0`).
  - `cnt` then increments, and `ones` increments when the bit is 1.
- **Word completion.** When the bit accepted with `cnt==WIDTH-1` arrives, it is the last bit of the word. On that same edge:
  - `out_data` loads `acc` with the new bit merged in.
  - `out_ones` loads `ones + in_bit`.
  - `out_valid` is set to 1.
  - `acc`, `cnt` and `ones` return to 0.
- **Output FSM.**
  - EMPTY (`out_valid=0`) moves to FULL when a word completes.
  - FULL moves to EMPTY on `out_ready` when no word completes that cycle.
  - FULL stays FULL when `out_ready` and a word completes in the same cycle. The new word replaces the old one and `out_valid` stays at 1 with no bubble.
  - FULL holds when `out_ready=0`. `out_data` and `out_ones` must stay stable until the word is taken.
- **`in_ready`** is `!(cnt==WIDTH-1 && out_valid && !out_ready)`. It is combinational from `out_ready`, with no path from `in_valid`. Bits 0..WIDTH-2 of the next word are always accepted, even while FULL.
- **`clear`.**
  - Zeroes `acc`, `cnt` and `ones`, and accepts no bit that cycle, even if `in_valid && in_ready`.
  - Does not touch the output register: a held word stays valid and `out_ready` is still honoured.
- **Arithmetic.** `ones` and `out_ones` are unsigned CW-bit values and cannot overflow, since the maximum is WIDTH.
- **Bits outside a word.** Bits not yet packed into a full word never appear on the output.

## Timing

- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_ones=0`.
  - `acc=0`, `cnt=0`, `ones=0`, output FSM in EMPTY.
  - `in_ready=1`.
- **Reset mid-word or mid-hold.** Asserting `rst_n=0` forces all of the reset values immediately (asynchronously). The partial word and any held word are lost. Release is synchronous to `clk`.
- **Latency.** The last bit is accepted at edge k, and `out_valid` is high in the cycle after edge k. Throughput is 1 bit per clock, i.e. 1 word per WIDTH clocks, with no bubbles when `out_ready=1`.
- **Backpressure.** When the last bit arrives while FULL and `out_ready=0`, `in_ready` is 0 and the bit is not consumed. Upstream must hold `in_bit`/`in_valid` until `in_ready=1`.
- **Release.** The cycle `out_ready` rises, `in_ready` rises with it, and the stalled last bit completes the new word on that same edge.
- **`clear` with a completing bit.** If `clear` and a would-be last bit coincide, `clear` wins: no word is produced and `out_valid` is unchanged, except that it still drops if `out_ready` takes the held word.

## Test plan

- **Basic packing.** With `WIDTH=8`, `LSB_FIRST=1` and `out_ready=1`, send bits 1,1,1,1,0,0,0,0, then 1,1,1,1,1,0,1,0. Required: `out_data=8'h0F` with `out_ones=4`, then `8'h5F` with `out_ones=6`. Each `out_valid` pulse lasts one cycle and occurs the cycle after the 8th bit.
- **Bit order.** With `LSB_FIRST=0`, send 0,0,0,1,1,0,0,1. Required: `out_data=8'h19` (25) and `out_ones=3`.
- **Backpressure.** Hold `out_ready=0` and stream 16 bits encoding 0x05, then 0x03. Required:
  - the first word is held stable;
  - `in_ready` drops after 15 accepted bits and the 16th bit is stalled;
  - raising `out_ready` transfers 0x05, and the next cycle shows `out_data=8'h03` with `out_ones=2`.
- **Clear mid-word.** Send 5 bits, pulse `clear` with `in_valid=1`, then send 1,1,1,1,1,1,1,1. Required: exactly one word, `8'hFF` with `out_ones=8`. The bit presented during `clear` is discarded.
- **Back-to-back completion.** While FULL, let the last bit of the next word arrive in the same cycle `out_ready=1`. Required: `out_valid` stays 1 across the edge and `out_data` switches words with no gap.
- **Reset mid-operation.** Send 3 bits with a word held, then pulse `rst_n=0` asynchronously between edges. Required:
  - immediately `out_valid=0`, `out_data=0`, `out_ones=0`, `in_ready=1`;
  - after release, the next 8 bits form a fresh word.
